// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: EX/MEM register, data-memory handshake, load/store alignment, WB register.
// Latency: ALU/jump ops reach WB one edge after capture; memory ops take one more edge per dmem_ready-low cycle.
// Backpressure: stall (combinational) holds upstream while an access waits for dmem_ready; abandoned after MAX_WAIT cycles.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   EB, ex_valid        Execute bundle and its valid flag; stall asks upstream to hold both
//   dmem_*              request/ready data-memory port (word address, byte enables, replicated store data)
//   wb_*                registered write-back record
//   misalign_fault      one-cycle pulse with the wb_valid of a misaligned access
//   bus_timeout         one-cycle pulse with the wb_valid of an abandoned access

typedef logic [1:0] result_sel_t;

typedef struct packed {
    logic [31:0] instr;
    logic [31:0] ALUResult;
    logic [31:0] RD2;
    logic [4:0]  rd;
    logic        RegW;
    logic        WE;
    result_sel_t ResultSelect;
    logic [31:0] PC4;
} Execute_Bundle;

module mem_access_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  Execute_Bundle EB,
    input  logic          ex_valid,
    output logic          stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [31:0]   dmem_addr,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_ready,
    input  logic [31:0]   dmem_rdata,
    output logic          wb_valid,
    output logic          wb_regw,
    output logic [4:0]    wb_rd,
    output result_sel_t   wb_result_select,
    output logic [31:0]   wb_alu_result,
    output logic [31:0]   wb_load_data,
    output logic [31:0]   wb_pc4,
    output logic          misalign_fault,
    output logic          bus_timeout
);

    localparam logic [6:0]    LOAD_OP = 7'b0000011;
    localparam int            CW      = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CW-1:0] LAST    = CW'(MAX_WAIT - 1);

    typedef enum logic {IDLE, ACCESS} state_e;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction

    Execute_Bundle m_q;
    logic          m_valid_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        wb_valid_q, wb_regw_q, misalign_q, timeout_q;
    logic [4:0]  wb_rd_q;
    result_sel_t wb_rs_q;
    logic [31:0] wb_alu_q, wb_load_q, wb_pc4_q;

    logic        ex_access, m_load, m_store, m_misalign, in_access, timeout_now;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    logic [31:0] shifted, load_val;
    logic        f3_ok, wb_regw_d;
    logic [31:0] wb_load_d;

    // A new access starts only for a real, aligned load or store being captured.
    assign ex_access = ex_valid
                     & ((EB.instr[6:0] == LOAD_OP) | EB.WE)
                     & !is_misaligned(EB.instr[14:12], EB.ALUResult[1:0]);

    assign m_f3       = m_q.instr[14:12];
    assign m_off      = m_q.ALUResult[1:0];
    assign m_load     = (m_q.instr[6:0] == LOAD_OP);
    assign m_store    = m_q.WE;
    assign m_misalign = m_valid_q & (m_load | m_store) & is_misaligned(m_f3, m_off);

    // ACCESS is only ever entered with an aligned memory op in M, so it alone gates the request.
    assign in_access   = (state_q == ACCESS);
    assign timeout_now = in_access & !dmem_ready & (cnt_q == LAST);
    assign stall       = in_access & !dmem_ready & !timeout_now;

    assign dmem_req  = in_access;
    assign dmem_we   = m_store;
    assign dmem_addr = {m_q.ALUResult[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = m_q.RD2;
        if (m_store) begin
            case (m_f3[1:0])
                2'b00: begin
                    dmem_be    = 4'b0001 << m_off;
                    dmem_wdata = {4{m_q.RD2[7:0]}};
                end
                2'b01: begin
                    dmem_be    = 4'b0011 << m_off;
                    dmem_wdata = {2{m_q.RD2[15:0]}};
                end
                default: begin
                    dmem_be    = 4'b1111;
                    dmem_wdata = m_q.RD2;
                end
            endcase
        end
    end

    // Load alignment and extension; unknown load widths produce zero and suppress the write.
    assign shifted = dmem_rdata >> {m_off, 3'b000};
    always_comb begin
        load_val = '0;
        f3_ok    = 1'b1;
        case (m_f3)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = shifted;
            3'b100:  load_val = {24'b0, shifted[7:0]};
            3'b101:  load_val = {16'b0, shifted[15:0]};
            default: f3_ok = 1'b0;
        endcase
    end

    // Load data is only meaningful on the ready cycle; timeouts and non-loads write zero.
    assign wb_load_d = (m_load & in_access & dmem_ready) ? load_val : 32'b0;
    assign wb_regw_d = m_valid_q & m_q.RegW & !m_misalign & !timeout_now & !(m_load & !f3_ok);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!stall) begin
            // Completion/abandon edge doubles as a capture edge, so a new access follows with no gap.
            state_d = ex_access ? ACCESS : IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            m_valid_q <= 1'b0;
            m_q       <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!stall) begin
                m_valid_q <= ex_valid;
                m_q       <= EB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q <= 1'b0;
            wb_regw_q  <= 1'b0;
            wb_rd_q    <= '0;
            wb_rs_q    <= '0;
            wb_alu_q   <= '0;
            wb_load_q  <= '0;
            wb_pc4_q   <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else if (!stall) begin
            wb_valid_q <= m_valid_q;
            wb_regw_q  <= wb_regw_d;
            wb_rd_q    <= m_q.rd;
            wb_rs_q    <= m_q.ResultSelect;
            wb_alu_q   <= m_q.ALUResult;
            wb_load_q  <= wb_load_d;
            wb_pc4_q   <= m_q.PC4;
            misalign_q <= m_misalign;
            timeout_q  <= timeout_now;
        end else begin
            // Bubble while the access is still waiting.
            wb_valid_q <= 1'b0;
            wb_regw_q  <= 1'b0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end
    end

    assign wb_valid         = wb_valid_q;
    assign wb_regw          = wb_regw_q;
    assign wb_rd            = wb_rd_q;
    assign wb_result_select = wb_rs_q;
    assign wb_alu_result    = wb_alu_q;
    assign wb_load_data     = wb_load_q;
    assign wb_pc4           = wb_pc4_q;
    assign misalign_fault   = misalign_q;
    assign bus_timeout      = timeout_q;

    // Only opcode and funct3 of the held instruction are decoded here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{m_q.instr[31:15], m_q.instr[11:7]};

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam logic [6:0] OP = 7'h33;
    localparam logic [6:0] LD = 7'h03;
    localparam logic [6:0] ST = 7'h23;

    logic          clk = 1'b0;
    logic          rst;
    Execute_Bundle eb;
    logic          ex_valid;
    logic          stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]    dmem_be;
    logic          wb_valid, wb_regw, misalign_fault, bus_timeout;
    logic [4:0]    wb_rd;
    result_sel_t   wb_result_select;
    logic [31:0]   wb_alu_result, wb_load_data, wb_pc4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst), .EB(eb), .ex_valid(ex_valid), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_regw(wb_regw), .wb_rd(wb_rd), .wb_result_select(wb_result_select),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data), .wb_pc4(wb_pc4),
        .misalign_fault(misalign_fault), .bus_timeout(bus_timeout)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        we;
        logic        regw;
        logic [31:0] alu;
        logic [31:0] rd2;
        logic [4:0]  rd;
        logic [1:0]  rs;
        logic [31:0] pc4;
        logic [31:0] rdata;
        int          delay;
        logic        e_req;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_reqc;
        int          e_stallc;
        int          e_lat;
        logic        e_regw;
        logic [31:0] e_load;
        logic        e_mis;
        logic        e_to;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (case %0d): got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic we, input logic regw,
                       input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] rd,
                       input logic [1:0] rs, input logic [31:0] pc4, input logic [31:0] rdata,
                       input int delay, input logic e_req, input logic [3:0] e_be,
                       input logic [31:0] e_wdata, input int e_reqc, input int e_stallc,
                       input int e_lat, input logic e_regw, input logic [31:0] e_load,
                       input logic e_mis, input logic e_to);
        vec_t v;
        v.op = op; v.f3 = f3; v.we = we; v.regw = regw; v.alu = alu; v.rd2 = rd2;
        v.rd = rd; v.rs = rs; v.pc4 = pc4; v.rdata = rdata; v.delay = delay;
        v.e_req = e_req; v.e_be = e_be; v.e_wdata = e_wdata; v.e_reqc = e_reqc;
        v.e_stallc = e_stallc; v.e_lat = e_lat; v.e_regw = e_regw; v.e_load = e_load;
        v.e_mis = e_mis; v.e_to = e_to;
        tv.push_back(v);
    endtask

    function automatic Execute_Bundle mk_eb(input logic [6:0] op, input logic [2:0] f3, input logic we,
                                            input logic regw, input logic [31:0] alu, input logic [31:0] rd2,
                                            input logic [4:0] rd, input logic [1:0] rs, input logic [31:0] pc4);
        Execute_Bundle b;
        b.instr        = {17'h1ABCD, f3, 5'b10101, op};
        b.ALUResult    = alu;
        b.RD2          = rd2;
        b.rd           = rd;
        b.RegW         = regw;
        b.WE           = we;
        b.ResultSelect = rs;
        b.PC4          = pc4;
        return b;
    endfunction

    task automatic run_vec(input int i);
        vec_t        v;
        logic [31:0] f_addr, f_wdata;
        logic [3:0]  f_be;
        logic        f_we, seen, moved, done;
        int          waited, reqc, stallc, edges;
        v = tv[i];
        seen = 0; moved = 0; done = 0; waited = 0; reqc = 0; stallc = 0;
        f_addr = '0; f_wdata = '0; f_be = '0; f_we = 0;
        @(negedge clk);
        eb = mk_eb(v.op, v.f3, v.we, v.regw, v.alu, v.rd2, v.rd, v.rs, v.pc4);
        ex_valid = 1'b1;
        dmem_ready = 1'b0;
        @(negedge clk);
        ex_valid = 1'b0;
        edges = 1;
        for (int c = 0; c < 20 && !done; c++) begin
            dmem_rdata = v.rdata;
            if (dmem_req) begin
                if (!seen) begin
                    seen = 1; f_addr = dmem_addr; f_be = dmem_be; f_we = dmem_we; f_wdata = dmem_wdata;
                end else if (dmem_addr !== f_addr || dmem_be !== f_be || dmem_we !== f_we ||
                             (f_we && dmem_wdata !== f_wdata)) begin
                    moved = 1;
                end
                reqc++;
                dmem_ready = (waited == v.delay);
                if (!dmem_ready) waited++;
            end else begin
                dmem_ready = 1'b0;
            end
            #1;
            if (stall) stallc++;
            @(negedge clk);
            dmem_ready = 1'b0;
            edges++;
            if (wb_valid) done = 1;
        end
        chk("wb_arrived", i, 32'(done), 32'd1);
        chk("req_seen", i, 32'(seen), 32'(v.e_req));
        if (v.e_req) begin
            chk("dmem_addr", i, f_addr, {v.alu[31:2], 2'b00});
            chk("dmem_be", i, 32'(f_be), 32'(v.e_be));
            chk("dmem_we", i, 32'(f_we), 32'(v.we));
            if (v.we) chk("dmem_wdata", i, f_wdata, v.e_wdata);
            chk("req_stable", i, 32'(moved), 32'd0);
        end
        chk("req_cycles", i, 32'(reqc), 32'(v.e_reqc));
        chk("stall_cycles", i, 32'(stallc), 32'(v.e_stallc));
        chk("latency", i, 32'(edges), 32'(v.e_lat));
        chk("wb_regw", i, 32'(wb_regw), 32'(v.e_regw));
        chk("wb_rd", i, 32'(wb_rd), 32'(v.rd));
        chk("wb_result_select", i, 32'(wb_result_select), 32'(v.rs));
        chk("wb_alu_result", i, wb_alu_result, v.alu);
        chk("wb_load_data", i, wb_load_data, v.e_load);
        chk("wb_pc4", i, wb_pc4, v.pc4);
        chk("misalign_fault", i, 32'(misalign_fault), 32'(v.e_mis));
        chk("bus_timeout", i, 32'(bus_timeout), 32'(v.e_to));
        @(negedge clk);
        chk("wb_valid_pulse", i, 32'(wb_valid), 32'd0);
        chk("fault_pulse", i, 32'({misalign_fault, bus_timeout}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        //   op  f3  we regw alu           rd2           rd  rs  pc4        rdata         dly req be     wdata         rc sc lat regw load          mis to
        add(OP, 0, 0, 1, 32'h0000_0010, 32'h0,        5,  0, 32'h104, 32'h0,        0,  0, 4'h0, 32'h0,        0, 0, 2, 1, 32'h0,        0, 0);
        add(LD, 0, 0, 1, 32'h0000_1003, 32'h0,        7,  1, 32'h108, 32'h80FF_0000, 3, 1, 4'hF, 32'h0,        4, 3, 5, 1, 32'hFFFF_FF80, 0, 0);
        add(ST, 1, 1, 0, 32'h0000_2002, 32'hDEAD_BEEF, 0, 2, 32'h10C, 32'h0,        0,  1, 4'hC, 32'hBEEF_BEEF, 1, 0, 2, 0, 32'h0,        0, 0);
        add(LD, 2, 0, 1, 32'h0000_0006, 32'h0,        9,  3, 32'h110, 32'h0,        0,  0, 4'h0, 32'h0,        0, 0, 2, 0, 32'h0,        1, 0);
        add(LD, 2, 0, 1, 32'h0000_0100, 32'h0,        10, 0, 32'h114, 32'h1111_1111, 99, 1, 4'hF, 32'h0,       4, 3, 5, 0, 32'h0,        0, 1);
        add(LD, 5, 0, 1, 32'h0000_3002, 32'h0,        11, 1, 32'h118, 32'h8001_1234, 1, 1, 4'hF, 32'h0,        2, 1, 3, 1, 32'h0000_8001, 0, 0);
        add(LD, 1, 0, 1, 32'h0000_3002, 32'h0,        12, 2, 32'h11C, 32'h8001_1234, 0, 1, 4'hF, 32'h0,        1, 0, 2, 1, 32'hFFFF_8001, 0, 0);
        add(LD, 4, 0, 1, 32'h0000_4001, 32'h0,        13, 3, 32'h120, 32'h1234_56F0, 2, 1, 4'hF, 32'h0,        3, 2, 4, 1, 32'h0000_0056, 0, 0);
        add(ST, 0, 1, 0, 32'h0000_5003, 32'h0000_00A5, 0, 0, 32'h124, 32'h0,        0,  1, 4'h8, 32'hA5A5_A5A5, 1, 0, 2, 0, 32'h0,        0, 0);
        add(ST, 2, 1, 0, 32'h0000_6000, 32'h1234_5678, 0, 1, 32'h128, 32'h0,        1,  1, 4'hF, 32'h1234_5678, 2, 1, 3, 0, 32'h0,        0, 0);
        add(ST, 1, 1, 0, 32'h0000_2001, 32'h0000_BEEF, 0, 2, 32'h12C, 32'h0,        0,  0, 4'h0, 32'h0,        0, 0, 2, 0, 32'h0,        1, 0);
        add(LD, 2, 0, 1, 32'h0000_0008, 32'h0,        14, 3, 32'h130, 32'hCAFE_F00D, 0, 1, 4'hF, 32'h0,        1, 0, 2, 1, 32'hCAFE_F00D, 0, 0);
        add(LD, 3, 0, 1, 32'h0000_0010, 32'h0,        15, 0, 32'h134, 32'hFFFF_FFFF, 0, 1, 4'hF, 32'h0,        1, 0, 2, 0, 32'h0,        0, 0);
        add(LD, 1, 0, 1, 32'h0000_0003, 32'h0,        16, 1, 32'h138, 32'h0,        0,  0, 4'h0, 32'h0,        0, 0, 2, 0, 32'h0,        1, 0);
        add(LD, 2, 0, 1, 32'h0000_0044, 32'h0,        17, 2, 32'h13C, 32'h0BAD_F00D, 3, 1, 4'hF, 32'h0,        4, 3, 5, 1, 32'h0BAD_F00D, 0, 0);

        // Reset state
        rst = 1'b1; ex_valid = 1'b0; eb = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_wb_valid", 0, 32'(wb_valid), 32'd0);
        chk("rst_wb_regw", 0, 32'(wb_regw), 32'd0);
        chk("rst_wb_fields", 0, {wb_rd, 25'(wb_result_select)} | wb_alu_result | wb_load_data | wb_pc4, 32'd0);
        chk("rst_faults", 0, 32'({misalign_fault, bus_timeout}), 32'd0);
        chk("rst_req_stall", 0, 32'({dmem_req, stall}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) run_vec(i);

        // Back-to-back: store captured on the load's completion edge requests immediately.
        @(negedge clk);
        eb = mk_eb(LD, 3'd2, 1'b0, 1'b1, 32'h20, 32'h0, 5'd20, 2'd1, 32'h200);
        ex_valid = 1'b1;
        @(negedge clk);
        eb = mk_eb(ST, 3'd2, 1'b1, 1'b0, 32'h24, 32'h77, 5'd0, 2'd0, 32'h204);
        #1;
        chk("b2b_req_c1", 100, 32'(dmem_req), 32'd1);
        chk("b2b_stall_c1", 100, 32'(stall), 32'd1);
        @(negedge clk);
        dmem_ready = 1'b1; dmem_rdata = 32'h55AA_55AA;
        #1;
        chk("b2b_stall_ready", 100, 32'(stall), 32'd0);
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("b2b_req_next", 100, 32'(dmem_req), 32'd1);
        chk("b2b_addr_next", 100, dmem_addr, 32'h24);
        chk("b2b_we_next", 100, 32'(dmem_we), 32'd1);
        chk("b2b_load_wb_valid", 100, 32'(wb_valid), 32'd1);
        chk("b2b_load_data", 100, wb_load_data, 32'h55AA_55AA);
        chk("b2b_load_rd", 100, 32'(wb_rd), 32'd20);
        dmem_ready = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("b2b_store_wb_valid", 100, 32'(wb_valid), 32'd1);
        chk("b2b_store_regw", 100, 32'(wb_regw), 32'd0);
        chk("b2b_req_done", 100, 32'(dmem_req), 32'd0);

        // Reset in the second wait cycle; the late ready must be ignored.
        @(negedge clk);
        eb = mk_eb(LD, 3'd2, 1'b0, 1'b1, 32'h40, 32'h0, 5'd21, 2'd0, 32'h300);
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
        chk("rstmid_req_c1", 101, 32'(dmem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; dmem_ready = 1'b1; dmem_rdata = 32'h9999_9999;
        #1;
        chk("rstmid_req", 101, 32'(dmem_req), 32'd0);
        chk("rstmid_stall", 101, 32'(stall), 32'd0);
        chk("rstmid_wb_valid", 101, 32'(wb_valid), 32'd0);
        begin
            int wbs;
            wbs = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                dmem_ready = 1'b0;
                if (wb_valid || wb_regw || dmem_req) wbs++;
            end
            chk("rstmid_no_writeback", 101, 32'(wbs), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline stage directly downstream of Execute. It registers the Execute_Bundle (EX/MEM boundary), performs loads and stores against a variable-latency data-memory port with a req/ready handshake, and aligns, extends and masks the data. It presents a registered write-back record to the register-file stage. While a memory access is outstanding it stalls everything upstream.

## Interface
- MAX_WAIT, 255: maximum cycles an access may wait for dmem_ready before it is abandoned (≥1).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- EB  in  Execute_Bundle  fields used: instr, ALUResult, RD2, rd, RegW, WE, ResultSelect, PC4.
- ex_valid  in  1  EB carries a real instruction this cycle.
- stall  out  1  combinational; upstream holds EB/ex_valid stable while high.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  {ALUResult[31:2],2'b00}.
- dmem_be  out  4  byte enables (stores; all-ones for loads).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ready  in  1  access completes this cycle.
- dmem_rdata  in  32  load data, valid when dmem_ready=1.
- wb_valid, wb_regw  out  1 each  write-back record valid / register write enable.
- wb_rd  out  5  destination register.
- wb_result_select  out  ResultSelect type  passthrough of EB.ResultSelect.
- wb_alu_result, wb_load_data, wb_pc4  out  32 each.
- misalign_fault, bus_timeout  out  1 each  one-cycle pulses, aligned with the faulting wb_valid.

## Operation
- M register: captures EB, with m_valid ← ex_valid, on every edge where stall=0. It holds while stall=1.
- Load: instr[6:0]=7'b0000011. Store: WE=1. funct3 = instr[14:12].
- Misalignment:
  - Halfword (funct3[1:0]=01) with addr[0]=1.
  - Word (10) with addr[1:0]≠0.
  - A misaligned op issues no request, passes to WB in one cycle with wb_regw=0 and misalign_fault=1.
- dmem_req = m_valid & (load|store) & aligned & state=ACCESS-eligible. dmem_we = store.
- Store enables:
  - SB: be = 4'b0001 << addr[1:0].
  - SH: 4'b0011 << addr[1:0].
  - SW: 4'b1111.
- Store data: wdata = SB {4{RD2[7:0]}}, SH {2{RD2[15:0]}}, SW RD2.
- Load data: shift dmem_rdata right by 8*addr[1:0], then extend.
  - LB / LH: sign-extend from bit 7 / bit 15.
  - LBU / LHU: zero-extend.
  - LW: as-is.
  - Other funct3: zero, wb_regw=0.
- FSM:
  - IDLE: no access outstanding. Go to ACCESS when the M register captures an aligned load/store; wait counter ← 0.
  - ACCESS: dmem_req=1; counter increments each cycle dmem_ready=0.
    - On dmem_ready=1: complete; go to IDLE, or stay in ACCESS with counter 0 if another aligned mem op is captured the same edge.
    - On counter=MAX_WAIT-1 without ready: abandon; bus_timeout pulse, wb_regw=0; go to IDLE or new ACCESS as above.
- stall = (state=ACCESS) & !dmem_ready & !timeout_this_cycle.
- WB register: loads from M on every edge where M is not stalled. Otherwise wb_valid ← 0 (bubble).
  - wb_regw = m_valid & RegW & !fault.
  - Non-load ops: wb_load_data = 0.
- Non-memory ops and misaligned ops never stall.

## Timing
- Reset values:
  - m_valid=0, state=IDLE, counter=0.
  - All wb_* outputs 0, misalign_fault=0, bus_timeout=0.
  - dmem_req=0, stall=0.
- Latency from EB capture edge to wb outputs:
  - ALU/jump ops: 1 edge after capture, i.e. 2 edges from EB presentation.
  - Memory ops: 2 + N edges, where N = cycles dmem_ready was low.
- Handshake:
  - dmem_req, addr, we, be and wdata are stable from assertion until the ready edge.
  - dmem_ready sampled only while dmem_req=1; ignored otherwise.
  - Zero-wait memory (ready in the first req cycle) gives no stall.
- Back-to-back: a new mem op captured on the completion edge asserts dmem_req the next cycle with no idle gap.
- Reset mid-access: next cycle dmem_req=0, the transaction is dropped, and a late dmem_ready is ignored.
- Simultaneous ready and timeout: ready wins; no timeout pulse.

## Test plan
- ADD result 0x0000_0010, rd=5, RegW=1, ex_valid=1 → 2 edges later wb_valid=1, wb_rd=5, wb_alu_result=0x10, stall never high.
- LB at addr 0x1003, rdata=0x80FF_0000, ready after 3 cycles → stall high 3 cycles, dmem_addr=0x1000, wb_load_data=0xFFFF_FF80.
- SH at addr 0x2002, RD2=0xDEAD_BEEF, zero-wait → dmem_be=4'b1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, one req cycle.
- LW at addr 0x0000_0006 → no dmem_req, misalign_fault pulse with wb_valid=1, wb_regw=0.
- MAX_WAIT=4, load, ready never asserted → req held 4 cycles, bus_timeout pulse, wb_regw=0, stall drops.
- rst asserted in the 2nd wait cycle, ready arrives next cycle → dmem_req=0, wb_valid=0, state IDLE, no write-back.
